// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer family:
// bit-order mode constants and a constant-evaluable ceiling log2.
package deser_pkg;

    localparam bit MODE_LSB_FIRST = 1'b1;
    localparam bit MODE_MSB_FIRST = 1'b0;

    // Bits needed to address 'value' distinct states (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value)
            result++;
        return result;
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Modulo-MODULUS bit counter; wrap flags the increment that completes a word.
module deser_bit_counter #(
    parameter int MODULUS = 32,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          wrap
);

    assign wrap = inc && (count == CW'(MODULUS - 1));

    // A clear that coincides with an increment still lands on zero: the bit was
    // counted into the word being emitted, not into the next one.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement or process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (wrap || clr)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from qualified
// serial bits, with partial-word flush and configurable bit order.
module param_deserializer
    import deser_pkg::*;
#(
    parameter int   WIDTH     = 32,
    parameter bit   LSB_FIRST = 1'b1,
    localparam int  CW        = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             datain,
    input  logic             validIn,
    input  logic             flush,
    output logic [WIDTH-1:0] dataout,
    output logic             validOut,
    output logic [CW-1:0]    nbits,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    fill;
    logic             wrap;
    logic             emit;

    deser_bit_counter #(
        .MODULUS (WIDTH),
        .CW      (CW)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (validIn),
        .clr   (flush),
        .count (count),
        .wrap  (wrap)
    );

    // fill counts the incoming bit too, so a same-edge bit+flush emits it.
    // NOTE: every always_comb output gets a default before any conditional
    // update, otherwise an untaken branch would infer a latch.
    always_comb begin
        pos      = (LSB_FIRST == MODE_LSB_FIRST) ? count : CW'(WIDTH - 1) - count;
        fill     = count + CW'(validIn);
        acc_next = acc;
        for (int i = 0; i < WIDTH; i++) begin
            if (validIn && pos == CW'(i))
                acc_next[i] = datain;
        end
        emit = wrap || (flush && fill != '0);
    end

    // Clearing the accumulator on every emission is what zero-fills the
    // unreceived positions of a later partial flush.
    // NOTE: the accumulator is a plain register, not a memory, so it takes the
    // reset like any other state and a reset mid-word discards its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            dataout  <= '0;
            nbits    <= '0;
            validOut <= 1'b0;
        end else begin
            validOut <= emit;
            if (emit) begin
                dataout <= acc_next;
                nbits   <= fill;
                acc     <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_param_deserializer.sv
// Scoreboard bench: three deserializer configurations, expected words queued
// at stimulus time and checked by per-instance monitors on each validOut.
module tb_param_deserializer;

    typedef struct {
        logic [31:0] data;
        int          nbits;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // WIDTH=8, LSB first
    logic       d8l, v8l, f8l, vo8l;
    logic [7:0] do8l;
    logic [3:0] nb8l, cnt8l;
    // WIDTH=8, MSB first
    logic       d8m, v8m, f8m, vo8m;
    logic [7:0] do8m;
    logic [3:0] nb8m, cnt8m;
    // WIDTH=32, LSB first
    logic        d32, v32, f32, vo32;
    logic [31:0] do32;
    logic [5:0]  nb32, cnt32;

    param_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u8l (
        .clk(clk), .rst(rst), .datain(d8l), .validIn(v8l), .flush(f8l),
        .dataout(do8l), .validOut(vo8l), .nbits(nb8l), .count(cnt8l));

    param_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (
        .clk(clk), .rst(rst), .datain(d8m), .validIn(v8m), .flush(f8m),
        .dataout(do8m), .validOut(vo8m), .nbits(nb8m), .count(cnt8m));

    param_deserializer #(.WIDTH(32), .LSB_FIRST(1'b1)) u32 (
        .clk(clk), .rst(rst), .datain(d32), .validIn(v32), .flush(f32),
        .dataout(do32), .validOut(vo32), .nbits(nb32), .count(cnt32));

    exp_t q8l[$], q8m[$], q32[$];
    exp_t e8l, e8m, e32;
    int   p32[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && vo8l) begin
            if (q8l.size() == 0) check("u8l unexpected pulse", 1, 0);
            else begin
                e8l = q8l.pop_front();
                check("u8l dataout", 64'(do8l), 64'(e8l.data));
                check("u8l nbits", 64'(nb8l), 64'(e8l.nbits));
            end
        end
        if (!rst && vo8m) begin
            if (q8m.size() == 0) check("u8m unexpected pulse", 1, 0);
            else begin
                e8m = q8m.pop_front();
                check("u8m dataout", 64'(do8m), 64'(e8m.data));
                check("u8m nbits", 64'(nb8m), 64'(e8m.nbits));
            end
        end
        if (!rst && vo32) begin
            p32.push_back(cyc);
            if (q32.size() == 0) check("u32 unexpected pulse", 1, 0);
            else begin
                e32 = q32.pop_front();
                check("u32 dataout", 64'(do32), 64'(e32.data));
                check("u32 nbits", 64'(nb32), 64'(e32.nbits));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8l(input logic b, input logic fl);
        d8l = b; v8l = 1'b1; f8l = fl;
        tick();
        v8l = 1'b0; f8l = 1'b0;
    endtask

    task automatic send8m(input logic b);
        d8m = b; v8m = 1'b1;
        tick();
        v8m = 1'b0;
    endtask

    task automatic send32(input logic b);
        d32 = b; v32 = 1'b1;
        tick();
        v32 = 1'b0;
    endtask

    task automatic push8l(input logic [31:0] data, input int nb);
        exp_t e;
        e.data = data; e.nbits = nb;
        q8l.push_back(e);
    endtask

    logic [7:0]  serial8;
    logic [31:0] word32;
    int          wait_cycles;

    initial begin
        rst = 1'b1;
        {d8l, v8l, f8l, d8m, v8m, f8m, d32, v32, f32} = '0;
        #12;
        check("reset u8l dataout", 64'(do8l), 0);
        check("reset u8l nbits", 64'(nb8l), 0);
        check("reset u8l validOut", 64'(vo8l), 0);
        check("reset u8l count", 64'(cnt8l), 0);
        check("reset u8m dataout", 64'(do8m), 0);
        check("reset u32 count", 64'(cnt32), 0);
        #6 rst = 1'b0;
        tick();

        // LSB first, contiguous: 1,0,1,1,0,0,1,0 -> 0x4D
        serial8 = 8'b0100_1101;
        push8l(32'h4D, 8);
        for (int i = 0; i < 8; i++) send8l(serial8[i], 1'b0);
        check("u8l pulse one cycle after last bit", 64'(vo8l), 1);
        tick();
        check("u8l pulse ends", 64'(vo8l), 0);
        check("u8l dataout held", 64'(do8l), 64'h4D);
        check("u8l nbits held", 64'(nb8l), 8);

        // MSB first, same bits with two idle cycles after bit 3 -> 0xB2
        q8m.push_back('{data: 32'hB2, nbits: 8});
        for (int i = 0; i < 8; i++) begin
            send8m(serial8[i]);
            if (i == 3) begin
                tick();
                tick();
                check("u8m count holds over gap", 64'(cnt8m), 4);
            end
        end

        // Partial flush of 1,1,1 -> 0x07, then an all-zero word
        push8l(32'h07, 3);
        for (int i = 0; i < 3; i++) send8l(1'b1, 1'b0);
        f8l = 1'b1;
        tick();
        f8l = 1'b0;
        check("u8l count cleared by flush", 64'(cnt8l), 0);
        push8l(32'h00, 8);
        for (int i = 0; i < 8; i++) send8l(1'b0, 1'b0);

        // WIDTH=32: two back-to-back words
        q32.push_back('{data: 32'hDEADBEEF, nbits: 32});
        q32.push_back('{data: 32'h12345678, nbits: 32});
        word32 = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) send32(word32[i]);
        word32 = 32'h12345678;
        for (int i = 0; i < 32; i++) send32(word32[i]);
        tick();
        check("u32 pulse count", 64'(p32.size()), 2);
        if (p32.size() == 2) check("u32 pulse spacing", 64'(p32[1] - p32[0]), 32);

        // Asynchronous reset mid-word, away from a clock edge
        for (int i = 0; i < 5; i++) send8l(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async reset u8l count", 64'(cnt8l), 0);
        check("async reset u8m dataout", 64'(do8m), 0);
        check("async reset u32 dataout", 64'(do32), 0);
        check("async reset u32 nbits", 64'(nb32), 0);
        #4 rst = 1'b0;
        tick();
        serial8 = 8'hA5;
        push8l(32'hA5, 8);
        for (int i = 0; i < 8; i++) send8l(serial8[i], 1'b0);

        // Flush on the word-completing bit, then flush at count 0
        serial8 = 8'h3C;
        push8l(32'h3C, 8);
        for (int i = 0; i < 8; i++) send8l(serial8[i], i == 7);
        check("u8l count after flush+full", 64'(cnt8l), 0);
        f8l = 1'b1;
        tick();
        f8l = 1'b0;
        check("u8l no pulse on empty flush", 64'(vo8l), 0);
        check("u8l dataout kept on empty flush", 64'(do8l), 64'h3C);
        check("u8l nbits kept on empty flush", 64'(nb8l), 8);

        wait_cycles = 0;
        while ((q8l.size() + q8m.size() + q32.size()) != 0 && wait_cycles < 20) begin
            tick();
            wait_cycles++;
        end
        check("u8l expected pulses outstanding", 64'(q8l.size()), 0);
        check("u8m expected pulses outstanding", 64'(q8m.size()), 0);
        check("u32 expected pulses outstanding", 64'(q32.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: output word width in bits, legal range 2..1024.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in dataout[0]; 0 = first received bit lands in dataout[WIDTH-1].
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port datain, input, 1 bit: serial data bit, sampled when validIn=1.
REQ-006 SHALL have port validIn, input, 1 bit: qualifies datain for this cycle.
REQ-007 SHALL have port flush, input, 1 bit: emits the current partial word.
REQ-008 SHALL have port dataout, output, WIDTH bits: assembled word, registered.
REQ-009 SHALL have port validOut, output, 1 bit: one-cycle pulse marking dataout as new.
REQ-010 SHALL have port nbits, output, CW = clog2(WIDTH+1) bits: count of valid bits in dataout, registered alongside it.
REQ-011 SHALL have port count, output, CW bits: bits currently accumulated, 0..WIDTH-1.

Function
REQ-012 SHALL, on each edge with validIn=1, write datain into accumulator position p, where p = count for LSB_FIRST=1 and p = WIDTH-1-count for LSB_FIRST=0, then increment count.
REQ-013 SHALL, on each edge with validIn=0 and flush=0, hold the accumulator and count unchanged; gaps between valid bits of any length are legal.
REQ-014 SHALL, on the edge accepting the WIDTH-th bit (count=WIDTH-1, validIn=1), load dataout with the full word including that bit, set nbits=WIDTH, pulse validOut for exactly the next cycle, and wrap count to 0.
REQ-015 SHALL give a latency of one cycle from sampling the last bit to validOut=1.
REQ-016 SHALL accept back-to-back words with no dead cycle: the bit after a word-completing bit is bit 0 of the next word.
REQ-017 SHALL hold dataout and nbits between validOut pulses; it SHALL NOT zero them.
REQ-018 SHALL, on an edge with flush=1 and count>0, load dataout with the received bits in their normal positions and zeros in all unreceived positions, set nbits=count, pulse validOut, clear the accumulator, and set count=0.
REQ-019 SHALL treat flush=1 with count=0 and validIn=0 as a no-op: no pulse, and dataout/nbits unchanged.
REQ-020 SHALL, when flush=1 and validIn=1 occur on the same edge, include datain first and then flush; if that bit completes the word, the result is a normal full-word emission with nbits=WIDTH.
REQ-021 SHALL clear the accumulator whenever it emits a word, so stale bits never appear in a later partial flush.

Reset
REQ-022 SHALL, while rst=1, force dataout=0, nbits=0, validOut=0, count=0, and the accumulator to 0, independent of clk.
REQ-023 SHALL discard a partially accumulated word when rst asserts mid-word; the first valid bit after release is bit 0 of a new word.
REQ-024 SHALL ignore validIn and flush on the first rising edge at which rst is 1.

Structure
REQ-025 SHALL import from shared package deser_pkg the clog2 function and the LSB_FIRST/MSB_FIRST mode constants.
REQ-026 SHALL instantiate one sub-module, deser_bit_counter (parametrised modulo-WIDTH counter with wrap flag); the shift/accumulate datapath stays in the top.

Verification
REQ-027 SHALL verify (WIDTH=8, LSB_FIRST=1): serial bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle later dataout=8'h4D, nbits=8, validOut high for one cycle.
REQ-028 SHALL verify (WIDTH=8, LSB_FIRST=0): the same bits with two idle cycles inserted after bit 3 -> dataout=8'hB2 with a single validOut pulse.
REQ-029 SHALL verify (WIDTH=8, LSB_FIRST=1): bits 1,1,1 then flush -> dataout=8'h07, nbits=3, count=0; a following full word of all zeros -> dataout=8'h00, proving the accumulator was cleared.
REQ-030 SHALL verify (WIDTH=32): 64 contiguous valid bits forming 32'hDEADBEEF then 32'h12345678 -> two pulses exactly 32 cycles apart carrying those words in order.
REQ-031 SHALL verify (WIDTH=8): rst asserted mid-edge after 5 bits -> outputs are 0 immediately; 8 new bits of 8'hA5 -> dataout=8'hA5 with no residue from before reset.
REQ-032 SHALL verify (WIDTH=8): flush with validIn=1 on the 8th bit -> one full-word pulse with nbits=8; flush at count=0 -> no pulse.
